// File: rtl/sorted_insert_ctrl.sv
// Sorted insert array controller: keeps DEPTH values in ascending
// unsigned order and drains them in order on flush.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data
// insert stream; flush drain request; out_valid/out_ready/out_data/
// out_last drain stream; count/full/empty occupancy; busy = not IDLE.
module sorted_insert_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FIND,
        INSERT,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] arr [DEPTH];
    logic [DATA_WIDTH-1:0] cap;
    logic [CNT_WIDTH-1:0]  pos;
    logic [CNT_WIDTH-1:0]  pos_calc;
    logic [CNT_WIDTH-1:0]  rd_ptr;
    logic [IDX_W-1:0]      rd_idx;

    assign rd_idx = rd_ptr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake outputs are gated by rst_n so nothing
    // is offered or accepted while reset is held.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = arr[rd_idx];
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                in_ready = rst_n && !full && !flush;
                if (flush) begin
                    if (!empty) state_nxt = DRAIN;
                end else if (in_valid && in_ready) begin
                    state_nxt = FIND;
                end
            end
            FIND:   state_nxt = INSERT;
            INSERT: state_nxt = IDLE;
            DRAIN: begin
                out_valid = rst_n;
                out_last  = rst_n &&
                            (rd_ptr == count - CNT_WIDTH'(1));
                if (out_valid && out_ready && out_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Insert position = number of live entries <= captured value,
    // so equal values land after existing ones.
    always_comb begin
        pos_calc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_WIDTH'(i) < count && arr[i] <= cap)
                pos_calc = pos_calc + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
            cap    <= '0;
            pos    <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) cap <= in_data;
                end
                FIND: pos <= pos_calc;
                INSERT: begin
                    if (pos == '0) arr[0] <= cap;
                    for (int i = 1; i < DEPTH; i++) begin
                        if (CNT_WIDTH'(i) == pos)
                            arr[i] <= cap;
                        else if (CNT_WIDTH'(i) > pos &&
                                 CNT_WIDTH'(i) <= count)
                            arr[i] <= arr[i-1];
                    end
                    count <= count + CNT_WIDTH'(1);
                    full  <= (count + CNT_WIDTH'(1) ==
                              CNT_WIDTH'(DEPTH));
                    empty <= 1'b0;
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            rd_ptr <= '0;
                            count  <= '0;
                            full   <= 1'b0;
                            empty  <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
